acortex_pcm_rd_arb: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for the acortex PCM buffer read port.

---
 rtl/acortex_pcm_rd_arb_if.sv | 16 +
 rtl/acortex_pcm_rd_arb.sv | 118 +++++++++++
 tb/tb_acortex_pcm_rd_arb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/acortex_pcm_rd_arb_if.sv
// rtl/acortex_pcm_rd_arb_if.sv - one requester channel of the acortex PCM read arbiter
interface acortex_pcm_rd_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   len;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              done;

    modport master (output valid, addr, len, input ack, rdata, rvalid, done);
    modport slave  (input valid, addr, len, output ack, rdata, rvalid, done);
endinterface

// File: rtl/acortex_pcm_rd_arb.sv
// rtl/acortex_pcm_rd_arb.sv - two-requester round-robin burst arbiter for the PCM read port
module acortex_pcm_rd_arb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pcm_rdy,
    acortex_pcm_rd_arb_if.slave req0,
    acortex_pcm_rd_arb_if.slave req1,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   rem;
    logic              owner, rr_ptr, first;
    logic [RD_LAT-1:0] pipe_v, pipe_o, pipe_l;
    logic              elig0, elig1, pick1, grant;
    logic              out_v, out_o, out_l;
    logic [ADDR_W:0]   sel_len;
    logic              ack, zdone, last_issue;

    assign elig0   = req0.valid && pcm_rdy;
    assign elig1   = req1.valid;
    // rr_ptr=1 means req1 wins a tie
    assign pick1   = elig1 && (!elig0 || rr_ptr);
    assign grant   = (state == IDLE) && (elig0 || elig1);
    assign sel_len = pick1 ? req1.len : req0.len;

    assign last_issue = mem_rd_en && (rem == (ADDR_W+1)'(1));
    assign out_v      = pipe_v[RD_LAT-1];
    assign out_o      = pipe_o[RD_LAT-1];
    assign out_l      = pipe_l[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_rd_en = 1'b0;
        ack       = 1'b0;
        zdone     = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 || elig1)
                    state_nxt = (sel_len == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                mem_rd_en = 1'b1;
                ack       = first;
                if (rem == (ADDR_W+1)'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_v && out_l) state_nxt = IDLE;
            end
            DONE: begin
                ack       = 1'b1;
                zdone     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt <= '0;
            rem      <= '0;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
            first    <= 1'b0;
            pipe_v   <= '0;
            pipe_o   <= '0;
            pipe_l   <= '0;
        end else begin
            if (grant) begin
                addr_cnt <= pick1 ? req1.addr : req0.addr;
                rem      <= sel_len;
                owner    <= pick1;
                rr_ptr   <= !pick1;
                first    <= 1'b1;
            end else if (mem_rd_en) begin
                addr_cnt <= addr_cnt + 1'b1;
                rem      <= rem - 1'b1;
                first    <= 1'b0;
            end
            // Return tag pipe matches the memory latency so tags line up with mem_rdata
            pipe_v[0] <= mem_rd_en;
            pipe_o[0] <= owner;
            pipe_l[0] <= last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_o[i] <= pipe_o[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
        end
    end

    assign mem_addr    = mem_rd_en ? addr_cnt : '0;
    assign busy        = (state != IDLE);

    assign req0.ack    = ack && !owner;
    assign req1.ack    = ack && owner;
    assign req0.rvalid = out_v && !out_o;
    assign req1.rvalid = out_v && out_o;
    assign req0.rdata  = req0.rvalid ? mem_rdata : '0;
    assign req1.rdata  = req1.rvalid ? mem_rdata : '0;
    assign req0.done   = (zdone && !owner) || (out_v && out_l && !out_o);
    assign req1.done   = (zdone && owner) || (out_v && out_l && out_o);
endmodule

// File: tb/tb_acortex_pcm_rd_arb.sv
// tb/tb_acortex_pcm_rd_arb.sv - randomized bench for acortex_pcm_rd_arb against a cycle schedule model
module tb_acortex_pcm_rd_arb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [8:0] l;
    } desc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pcm_rdy = 1'b1;
    logic mem_rd_en, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    acortex_pcm_rd_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) r0();
    acortex_pcm_rd_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) r1();

    acortex_pcm_rd_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .pcm_rdy(pcm_rdy),
        .req0(r0), .req1(r1),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] mp [RD_LAT];
    always @(posedge clk) begin
        mp[0] <= mem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) mp[i] <= mp[i-1];
    end
    assign mem_rdata = mp[RD_LAT-1];

    int n_chk = 0, n_err = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    desc_t q0[$], q1[$];
    int pushed0 = 0, pushed1 = 0;
    task automatic push(input int who, input int a, input int l);
        desc_t d;
        d.a = 8'(a);
        d.l = 9'(l);
        if (who == 0) begin q0.push_back(d); pushed0++; end
        else          begin q1.push_back(d); pushed1++; end
    endtask

    // Requesters hold the head descriptor until acked
    always @(posedge clk) begin
        #1;
        if (r0.ack) q0.delete(0);
        if (q0.size() != 0) begin r0.valid = 1'b1; r0.addr = q0[0].a; r0.len = q0[0].l; end
        else r0.valid = 1'b0;
        if (r1.ack) q1.delete(0);
        if (q1.size() != 0) begin r1.valid = 1'b1; r1.addr = q1[0].a; r1.len = q1[0].l; end
        else r1.valid = 1'b0;
    end

    // Model: expected outputs per cycle, bits {ack0,ack1,done0,done1,rv0,rv1,rd_en,busy}
    logic [7:0]  eb [int];
    logic [7:0]  ea [int];
    logic [63:0] ed [int];
    int  cyc = 0, idle_at = 0;
    bit  mon_en = 0;
    logic rr_m = 1'b0;
    int  obs_g[$];
    int  ack0_n = 0, ack1_n = 0, done0_n = 0, done1_n = 0;

    task automatic orb(input int c, input logic [7:0] m);
        if (eb.exists(c)) eb[c] = eb[c] | m;
        else eb[c] = m;
    endtask

    task automatic decide();
        logic e0, e1, o;
        logic [7:0] a;
        int L, w;
        e0 = r0.valid && pcm_rdy;
        e1 = r1.valid;
        if (e0 || e1) begin
            o = (e0 && e1) ? rr_m : e1;
            rr_m = !o;
            a = o ? r1.addr : r0.addr;
            L = o ? int'(r1.len) : int'(r0.len);
            orb(cyc + 1, o ? 8'h41 : 8'h81);
            if (L == 0) begin
                orb(cyc + 1, o ? 8'h10 : 8'h20);
                idle_at = cyc + 2;
            end else begin
                for (int i = 0; i < L; i++) begin
                    w = (int'(a) + i) % 256;
                    orb(cyc + 1 + i, 8'h02);
                    ea[cyc + 1 + i] = 8'(w);
                    orb(cyc + 1 + RD_LAT + i, o ? 8'h04 : 8'h08);
                    ed[cyc + 1 + RD_LAT + i] = o ? {32'h0, mem[w]} : {mem[w], 32'h0};
                end
                for (int c = cyc + 1; c <= cyc + L + RD_LAT; c++) orb(c, 8'h01);
                orb(cyc + L + RD_LAT, o ? 8'h10 : 8'h20);
                idle_at = cyc + L + RD_LAT + 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("flags", {r0.ack, r1.ack, r0.done, r1.done, r0.rvalid, r1.rvalid, mem_rd_en, busy},
                  eb.exists(cyc) ? eb[cyc] : 8'h00);
            check("mem_addr", mem_addr, ea.exists(cyc) ? ea[cyc] : 8'h00);
            check("rdata", {r0.rdata, r1.rdata}, ed.exists(cyc) ? ed[cyc] : 64'h0);
            if (r0.ack) begin ack0_n++; obs_g.push_back(0); end
            if (r1.ack) begin ack1_n++; obs_g.push_back(1); end
            if (r0.done) done0_n++;
            if (r1.done) done1_n++;
            if (cyc >= idle_at) decide();
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy || cyc < idle_at) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 64'(n < 3000), 64'd1);
    endtask

    initial begin
        int idx, n, r;
        r0.valid = 0; r0.addr = '0; r0.len = '0;
        r1.valid = 0; r1.addr = '0; r1.len = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {r0.ack, r1.ack, r0.done, r1.done, r0.rvalid, r1.rvalid, mem_rd_en, busy}, 8'h00);
        check("reset_addr", mem_addr, 8'h00);

        // Both requesters pending at reset exit: grants must alternate 0,1,0,1
        push(0, 8'h10, 4); push(0, 8'h20, 3);
        push(1, 8'h80, 2); push(1, 8'h90, 5);
        @(posedge clk); #1;
        rst_n = 1'b1; mon_en = 1;
        wait_idle();
        check("grant_count", 64'(obs_g.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_g.size(); i++)
            check("rr_order", 64'(obs_g[i]), 64'(i % 2));

        // req0 masked by pcm_rdy: req1 must go first
        idx = obs_g.size();
        pcm_rdy = 1'b0;
        push(0, 8'h70, 2); push(1, 8'h60, 3);
        repeat (15) @(posedge clk);
        #1; pcm_rdy = 1'b1;
        wait_idle();
        check("rdy_first", 64'(obs_g[idx]), 64'd1);
        check("rdy_second", 64'(obs_g[idx+1]), 64'd0);

        // Address wrap and zero-length bursts
        push(1, 8'hFE, 4); push(1, 8'h33, 0); push(0, 8'h00, 0);
        wait_idle();

        // Asynchronous reset with reads outstanding aborts req0's burst
        push(0, 8'h40, 8);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!r0.ack && n < 40);
        check("abort_ack_seen", 64'(r0.ack), 64'd1);
        repeat (3) @(posedge clk);
        #2; mon_en = 0; rst_n = 1'b0;
        #1;
        check("abort_flags", {r0.ack, r1.ack, r0.done, r1.done, r0.rvalid, r1.rvalid, mem_rd_en, busy}, 8'h00);
        check("abort_rdata", {r0.rdata, r1.rdata}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        eb.delete(); ea.delete(); ed.delete();
        rr_m = 1'b0; idle_at = 0;
        rst_n = 1'b1; mon_en = 1;
        push(1, 8'h50, 3);
        wait_idle();

        // Random traffic with pcm_rdy toggling
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            pcm_rdy = ($urandom % 10) < 7;
            for (int who = 0; who < 2; who++) begin
                if (((who == 0) ? q0.size() : q1.size()) < 2 && ($urandom % 4) == 0) begin
                    r = $urandom % 20;
                    push(who, $urandom % 256, (r == 0) ? 0 : (r == 1) ? 256 : 1 + $urandom % 8);
                end
            end
        end
        pcm_rdy = 1'b1;
        wait_idle();

        check("ack0_count", 64'(ack0_n), 64'(pushed0));
        check("ack1_count", 64'(ack1_n), 64'(pushed1));
        check("done0_count", 64'(done0_n), 64'(pushed0 - 1));
        check("done1_count", 64'(done1_n), 64'(pushed1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
